// File: rtl/controle_multiplicador.sv
// Shift-and-add multiply sequencer driving one shared external WIDTH-bit adder.
// One product bit per CALC cycle; the product is registered on entry to DONE.
module controle_multiplicador #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] s,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH:0]     add_s
);

  // state  | meaning
  // S_IDLE | waiting for start, ready=1
  // S_CALC | one shift-and-add step per cycle, WIDTH cycles
  // S_DONE | product valid in s, done pulse
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               r_state;
  state_t               w_next;
  logic [WIDTH-1:0]     r_m;
  logic [2*WIDTH-1:0]   r_p;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_s;
  logic [2*WIDTH-1:0]   w_shift;
  logic                 w_accept;
  logic                 w_last;

  // Adder carry lands in the top bit, so the shifted value never overflows.
  assign w_shift  = {add_s, r_p[WIDTH-1:1]};
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_CALC) && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    add_a  = '0;
    add_b  = '0;
    case (r_state)
      S_IDLE: if (start) w_next = S_CALC;
      S_CALC: begin
        add_a = r_p[2*WIDTH-1:WIDTH];
        add_b = r_p[0] ? r_m : '0;
        if (r_cnt == LAST) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m   <= '0;
      r_p   <= '0;
      r_cnt <= '0;
      r_s   <= '0;
    end else if (w_accept) begin
      r_m   <= a;
      r_p   <= {{WIDTH{1'b0}}, b};
      r_cnt <= '0;
    end else if (r_state == S_CALC) begin
      r_p   <= w_shift;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_s <= w_shift;
    end
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state == S_CALC) || (r_state == S_DONE);
  assign done  = (r_state == S_DONE);
  assign s     = r_s;

endmodule

// File: tb/tb_controle_multiplicador.sv
// Bench for controle_multiplicador (WIDTH=4) with a behavioural 4-bit adder on the
// shared-adder port and a queue of expected products checked at each done pulse.
module tb_controle_multiplicador;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] s;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W:0]     add_s;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int dones   = 0;
  int acc_cnt = 0;
  int last_done = -1;
  bit spacing_chk = 0;

  // Reference: cycles left until back in IDLE (5 = first CALC, 1 = DONE).
  int             m_cnt = 0;
  logic [W-1:0]   m_m = '0;
  logic [2*W-1:0] m_s = '0;
  logic [2*W-1:0] exp_q[$];

  controle_multiplicador #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done), .s(s),
    .add_a(add_a), .add_b(add_b), .add_s(add_s)
  );

  assign add_s = {1'b0, add_a} + {1'b0, add_b};

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_m   = '0;
      m_s   = '0;
      exp_q.delete();
    end else if (m_cnt == 0) begin
      if (start) begin
        exp_q.push_back({4'b0, a} * {4'b0, b});
        m_m   = a;
        m_cnt = W + 1;
        acc_cnt++;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 1) begin
        if (exp_q.size() > 0) m_s = exp_q.pop_front();
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_tests++;
      if (ready !== (m_cnt == 0)) begin
        n_fail++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, m_cnt == 0);
      end
      n_tests++;
      if (busy !== (m_cnt != 0)) begin
        n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_cnt != 0);
      end
      n_tests++;
      if (done !== (m_cnt == 1)) begin
        n_fail++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, m_cnt == 1);
      end
      n_tests++;
      if (s !== m_s) begin
        n_fail++; $display("FAIL s cyc=%0d got=%h exp=%h", cyc, s, m_s);
      end
      n_tests++;
      if (m_cnt >= 2) begin
        if (add_b !== 4'h0 && add_b !== m_m) begin
          n_fail++; $display("FAIL add_b_calc cyc=%0d got=%h exp=0_or_%h", cyc, add_b, m_m);
        end
      end else if (add_a !== 4'h0 || add_b !== 4'h0) begin
        n_fail++; $display("FAIL add_idle cyc=%0d got=%h/%h exp=0/0", cyc, add_a, add_b);
      end
      if (done) begin
        if (spacing_chk && last_done >= 0) begin
          n_tests++;
          if (cyc - last_done != W + 2) begin
            n_fail++; $display("FAIL spacing got=%0d exp=%0d", cyc - last_done, W + 2);
          end
        end
        last_done = cyc;
        dones++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while ((m_cnt != 0 || exp_q.size() != 0) && k < 40) begin step(); k++; end
    step();
    if (k >= 40) begin
      n_tests++; n_fail++;
      $display("FAIL timeout_%s got=%0d cycles exp<40", tag, k);
    end
  endtask

  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [2*W-1:0] exp_s, input string tag);
    int d0 = dones;
    int c_acc;
    int k = 0;
    a = ia; b = ib; start = 1;
    step();
    start = 0; a = $urandom_range(15); b = $urandom_range(15);
    c_acc = cyc;
    while (!done && k < 20) begin step(); k++; end
    n_tests++;
    if (cyc - c_acc != W) begin
      n_fail++; $display("FAIL latency_%s got=%0d exp=%0d", tag, cyc - c_acc, W);
    end
    n_tests++;
    if (s !== exp_s) begin
      n_fail++; $display("FAIL s_%s got=%h exp=%h", tag, s, exp_s);
    end
    wait_idle(tag);
    step();
    n_tests++;
    if (dones - d0 != 1) begin
      n_fail++; $display("FAIL done_count_%s got=%0d exp=1", tag, dones - d0);
    end
    n_tests++;
    if (s !== exp_s || done !== 1'b0) begin
      n_fail++; $display("FAIL hold_%s got=%h/%b exp=%h/0", tag, s, done, exp_s);
    end
  endtask

  task automatic test_reset();
    rst_n = 0; start = 0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || s !== 8'h00) begin
      n_fail++; $display("FAIL reset got=r%b b%b d%b s%h exp=r1 b0 d0 s00", ready, busy, done, s);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_basic();
    do_op(4'hF, 4'hF, 8'hE1, "15x15");
    do_op(4'hA, 4'h3, 8'h1E, "10x3");
    do_op(4'h0, 4'h9, 8'h00, "0x9");
    do_op(4'h7, 4'h0, 8'h00, "7x0");
  endtask

  task automatic test_back_to_back();
    int d0 = dones;
    int k;
    int target;
    last_done = -1;
    spacing_chk = 1;
    for (int i = 0; i < 256; i++) begin
      a = i[7:4]; b = i[3:0]; start = 1;
      target = acc_cnt + 1;
      k = 0;
      while (acc_cnt != target && k < 12) begin step(); k++; end
      if (k >= 12) begin
        n_tests++; n_fail++;
        $display("FAIL accept_timeout pair=%0d got=%0d exp=%0d", i, acc_cnt, target);
      end
    end
    start = 0;
    wait_idle("b2b");
    spacing_chk = 0;
    n_tests++;
    if (dones - d0 != 256) begin
      n_fail++; $display("FAIL b2b_dones got=%0d exp=256", dones - d0);
    end
  endtask

  task automatic test_start_ignored();
    int d0 = dones;
    a = 4'h3; b = 4'h5; start = 1;
    step();
    start = 0;
    step();
    a = 4'h9; b = 4'h9; start = 1;
    step();
    start = 0;
    wait_idle("ignore");
    n_tests++;
    if (dones - d0 != 1) begin
      n_fail++; $display("FAIL ignore_dones got=%0d exp=1", dones - d0);
    end
    n_tests++;
    if (s !== 8'h0F) begin
      n_fail++; $display("FAIL ignore_s got=%h exp=0f", s);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    a = 4'hF; b = 4'hF; start = 1;
    step();
    start = 0;
    step(); step();
    rst_n = 0;
    #1;
    n_tests++;
    if (s !== 8'h00 || done !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL midreset got=s%h d%b r%b exp=s00 d0 r1", s, done, ready);
    end
    step();
    rst_n = 1;
    d0 = dones;
    repeat (8) step();
    n_tests++;
    if (dones != d0) begin
      n_fail++; $display("FAIL midreset_no_done got=%0d exp=0", dones - d0);
    end
    do_op(4'h2, 4'h3, 8'h06, "2x3");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
